riscv_ifetch_buffer: RTL and testbench
======================================

Name: riscv_ifetch_buffer

Overview:
Instruction prefetch stage that sits between the synchronous-read I-memory (SP_SRAM, 1-cycle read latency) and the IF stage of riscv_core.
- Generates sequential fetch addresses and issues reads to I-memory.
- Queues returned instructions, each tagged with its PC, in a small FIFO.
- Presents them to the core with a valid/ready handshake.
- Redirects fetch on branch/jump flush, discarding stale entries and stale in-flight reads.

Parameters:
DEPTH, 4, FIFO entries; power of 2, minimum 2.
PTR_W, 2, log2(DEPTH); pointer width.
RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
CLK  input  1  system clock; all state updates on rising edge.
RSTn  input  1  asynchronous, active-low reset.
I_MEM_CSN  output  1  I-memory chip select, active low; low = read issued this cycle.
I_MEM_ADDR  output  32  byte address of the read; memory uses bits [11:2].
I_MEM_DI  input  32  I-memory read data; valid the cycle after I_MEM_CSN was low.
FLUSH  input  1  redirect request from the core (taken branch/jump).
FLUSH_PC  input  32  redirect target; sampled only when FLUSH=1.
HALT  input  1  when 1, no new reads are issued; queued entries still drain.
INST_READY  input  1  core accepts the head entry this cycle.
INST_VALID  output  1  head entry is valid.
INST  output  32  head instruction; 32'h0 when INST_VALID=0.
INST_PC  output  32  PC of the head instruction; 32'h0 when INST_VALID=0.

Behaviour:
- Reset (RSTn=0, asynchronous):
  - fetch_pc=RESET_PC; count=0; pointers=0; inflight=0.
  - Outputs: I_MEM_CSN=1, INST_VALID=0, INST=0, INST_PC=0.
  - Any in-flight read is forgotten.
- Issue condition:
  - issue = !HALT && (FLUSH || (count + inflight) < DEPTH).
  - count and inflight are the registered values.
  - I_MEM_CSN = !issue.
- Issue address:
  - I_MEM_ADDR = FLUSH ? FLUSH_PC : fetch_pc (combinational).
  - On issue: fetch_pc <= I_MEM_ADDR + 4, modulo 2^32 (wraps 32'hFFFF_FFFC -> 0).
- In-flight tracking:
  - inflight <= issue; inflight_pc <= I_MEM_ADDR.
  - Responses never overlap, because issue spacing is at most 1 per cycle and read latency is 1.
- Push:
  - When inflight=1 and FLUSH=0, {I_MEM_DI, inflight_pc} is written at the tail; tail++ and count++.
- Pop:
  - When INST_VALID && INST_READY && !FLUSH: head++ and count--.
  - Push and pop in the same cycle leave count unchanged.
- Outputs:
  - INST_VALID = (count != 0); INST/INST_PC come from the head entry.
  - There is no bypass, so a pushed entry is visible on the cycle after the push.
  - Redirect-to-valid latency is 2 cycles: FLUSH at t, read at t, push at end of t+1, INST_VALID at t+2.
- FLUSH (highest priority):
  - Same cycle: count, head and tail reset to 0.
  - The pending response (inflight=1 at t) is discarded, not pushed.
  - Pop is ignored.
  - A read at FLUSH_PC is issued in the same cycle unless HALT=1. With HALT=1, fetch_pc <= FLUSH_PC and no read is issued.
- Full:
  - When count + inflight == DEPTH, no issue occurs.
  - A push can never overflow, because space is reserved at issue.
- Empty:
  - INST_VALID=0; INST_READY is ignored.
- Steady state:
  - With INST_READY held 1, one instruction is delivered per cycle after an initial 2-cycle fill.
- HALT:
  - Freezes fetch_pc and issue.
  - An in-flight response is still pushed.
  - Deassertion resumes at fetch_pc.
- RSTn asserted mid-operation: the entire state is cleared immediately, and fetch restarts at RESET_PC after release.

Test Plan:
- Reset release, INST_READY=1, memory holding word n at address 4n:
  - I_MEM_ADDR = 0, 4, 8, ... on consecutive cycles.
  - INST_VALID first high 2 cycles after the first issue, with INST_PC=0.
  - Then one entry per cycle, in order, with INST_PC incrementing by 4.
- INST_READY=0 with DEPTH=4:
  - Exactly 4 reads issued (addresses 0..12), then I_MEM_CSN stays 1.
  - count=4; INST held at PC 0.
  - Raising INST_READY drains PCs 0, 4, 8, 12 with no gap, and issue resumes at 16.
- FLUSH=1, FLUSH_PC=32'h100, at a cycle with 3 entries queued and 1 read in flight:
  - I_MEM_ADDR=32'h100 in the same cycle.
  - INST_VALID=0 on the next cycle; no stale PC ever appears.
  - The first delivered entry is INST_PC=32'h100 two cycles after the flush, followed by 32'h104.
- Simultaneous pop and push at count=2:
  - count stays 2.
  - Order is preserved across pointer wrap (tail index 3 -> 0).
- HALT=1 with 1 read in flight:
  - The response is pushed and no further reads are issued.
  - After HALT=0, the next issue address equals the last issued address + 4.
- RSTn pulsed low mid-stream with entries queued:
  - INST_VALID=0 and I_MEM_CSN=1 immediately, without waiting for a clock edge.
  - After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/riscv_ifetch_buffer_if.sv
// riscv_ifetch_buffer_if: I-memory read port and core-side instruction handshake for the fetch buffer
// master (fetch buffer): drives I_MEM_CSN/I_MEM_ADDR and INST_VALID/INST/INST_PC
// slave (memory/core): drives I_MEM_DI, FLUSH/FLUSH_PC, HALT and INST_READY
interface riscv_ifetch_buffer_if;
  logic        I_MEM_CSN;
  logic [31:0] I_MEM_ADDR;
  logic [31:0] I_MEM_DI;
  logic        FLUSH;
  logic [31:0] FLUSH_PC;
  logic        HALT;
  logic        INST_READY;
  logic        INST_VALID;
  logic [31:0] INST;
  logic [31:0] INST_PC;
  modport master (
    output I_MEM_CSN, I_MEM_ADDR, INST_VALID, INST, INST_PC,
    input  I_MEM_DI, FLUSH, FLUSH_PC, HALT, INST_READY
  );
  modport slave (
    input  I_MEM_CSN, I_MEM_ADDR, INST_VALID, INST, INST_PC,
    output I_MEM_DI, FLUSH, FLUSH_PC, HALT, INST_READY
  );
endinterface

// File: rtl/riscv_ifetch_buffer.sv
// riscv_ifetch_buffer: sequential prefetch into a PC-tagged FIFO with flush redirect and halt
// CLK/RSTn: clock and asynchronous active-low reset
// bus (master): I-memory read port plus valid/ready instruction output to the core
module riscv_ifetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter int          PTR_W    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic CLK,
  input  logic RSTn,
  riscv_ifetch_buffer_if.master bus
);
  logic [31:0]      fetch_pc_q, fetch_pc_d, inflight_pc_q, addr;
  logic             inflight_q, issue, push, pop, valid;
  logic [PTR_W:0]   count_q, count_d;
  logic [PTR_W+1:0] occ;
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [31:0]      inst_mem [DEPTH];
  logic [31:0]      pc_mem   [DEPTH];
  // queued plus in-flight entries; space for a read is reserved when it issues
  assign occ = {1'b0, count_q} + {{(PTR_W+1){1'b0}}, inflight_q};
  always_comb begin
    valid      = count_q != '0;
    addr       = bus.FLUSH ? bus.FLUSH_PC : fetch_pc_q;
    issue      = RSTn && !bus.HALT && (bus.FLUSH || occ < (PTR_W+2)'(DEPTH));
    push       = inflight_q && !bus.FLUSH;
    pop        = valid && bus.INST_READY && !bus.FLUSH;
    fetch_pc_d = issue ? addr + 32'd4 : addr;
    head_d     = bus.FLUSH ? '0 : head_q + PTR_W'(pop);
    tail_d     = bus.FLUSH ? '0 : tail_q + PTR_W'(push);
    count_d    = bus.FLUSH ? '0 : count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
  end
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      count_q       <= '0;
      head_q        <= '0;
      tail_q        <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= issue;
      inflight_pc_q <= addr;
      count_q       <= count_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
    end
  end
  // entry storage needs no reset: it is only observed through count
  always_ff @(posedge CLK) begin
    if (push) begin
      inst_mem[tail_q] <= bus.I_MEM_DI;
      pc_mem[tail_q]   <= inflight_pc_q;
    end
  end
  assign bus.I_MEM_CSN  = !issue;
  assign bus.I_MEM_ADDR = addr;
  assign bus.INST_VALID = valid;
  assign bus.INST       = valid ? inst_mem[head_q] : '0;
  assign bus.INST_PC    = valid ? pc_mem[head_q] : '0;
endmodule

// File: tb/tb_riscv_ifetch_buffer.sv
// tb_riscv_ifetch_buffer: directed and randomized checks of the fetch buffer against a queue model
module tb_riscv_ifetch_buffer;
  localparam int DEPTH = 4;
  logic CLK = 1'b0;
  logic RSTn;
  riscv_ifetch_buffer_if bus();
  riscv_ifetch_buffer #(.DEPTH(DEPTH), .PTR_W(2), .RESET_PC(32'h0)) dut (.CLK(CLK), .RSTn(RSTn), .bus(bus));
  always #5 CLK = ~CLK;
  int total = 0;
  int bad = 0;
  logic [31:0] q[$];
  logic        m_inf;
  logic [31:0] m_ipc, m_fpc;
  logic        prev_iss;
  logic [31:0] prev_addr;
  logic        s_csn, s_valid;
  logic [31:0] s_addr, s_pc, s_inst;
  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", n, got, exp);
    end
  endtask
  task automatic sample();
    s_csn   = bus.I_MEM_CSN;
    s_addr  = bus.I_MEM_ADDR;
    s_valid = bus.INST_VALID;
    s_pc    = bus.INST_PC;
    s_inst  = bus.INST;
  endtask
  task automatic cycle(input logic fl, input logic [31:0] fpc, input logic h, input logic r);
    logic        e_iss, e_v;
    logic [31:0] e_addr, e_pc;
    bus.FLUSH      = fl;
    bus.FLUSH_PC   = fpc;
    bus.HALT       = h;
    bus.INST_READY = r;
    bus.I_MEM_DI   = prev_iss ? mem(prev_addr) : $urandom;
    #1;
    sample();
    e_v  = q.size() != 0;
    e_pc = 32'h0;
    if (e_v) e_pc = q[0];
    e_addr = fl ? fpc : m_fpc;
    e_iss  = !h && (fl || (q.size() + int'(m_inf)) < DEPTH);
    chk("csn", 32'(s_csn), 32'(!e_iss));
    chk("addr", s_addr, e_addr);
    chk("valid", 32'(s_valid), 32'(e_v));
    chk("inst_pc", s_pc, e_pc);
    chk("inst", s_inst, e_v ? mem(e_pc) : 32'h0);
    if (q.size() > DEPTH) chk("occupancy", q.size(), DEPTH);
    if (fl) q.delete();
    else begin
      if (e_v && r) void'(q.pop_front());
      if (m_inf) q.push_back(m_ipc);
    end
    m_inf     = e_iss;
    m_ipc     = e_addr;
    m_fpc     = e_iss ? e_addr + 32'd4 : e_addr;
    prev_iss  = !s_csn;
    prev_addr = s_addr;
    @(posedge CLK);
    @(negedge CLK);
  endtask
  task automatic do_reset();
    RSTn           = 1'b0;
    bus.HALT       = 1'b0;
    bus.FLUSH      = 1'b0;
    bus.INST_READY = 1'b1;
    #1;
    sample();
    chk("rst_csn", 32'(s_csn), 32'h1);
    chk("rst_valid", 32'(s_valid), 32'h0);
    chk("rst_inst", s_inst, 32'h0);
    chk("rst_pc", s_pc, 32'h0);
    @(posedge CLK);
    @(negedge CLK);
    RSTn = 1'b1;
    q.delete();
    m_inf    = 1'b0;
    m_ipc    = 32'h0;
    m_fpc    = 32'h0;
    prev_iss = 1'b0;
  endtask
  initial begin
    int n;
    RSTn           = 1'b1;
    bus.FLUSH      = 1'b0;
    bus.FLUSH_PC   = 32'h0;
    bus.HALT       = 1'b0;
    bus.INST_READY = 1'b0;
    bus.I_MEM_DI   = 32'h0;
    @(negedge CLK);
    do_reset();
    cycle(0, 0, 0, 1); chk("s_a0", s_addr, 32'h0); chk("s_v0", 32'(s_valid), 32'h0);
    cycle(0, 0, 0, 1); chk("s_a1", s_addr, 32'h4);
    cycle(0, 0, 0, 1); chk("s_a2", s_addr, 32'h8); chk("s_v2", 32'(s_valid), 32'h1); chk("s_pc2", s_pc, 32'h0);
    cycle(0, 0, 0, 1); chk("s_pc3", s_pc, 32'h4);
    do_reset();
    n = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(0, 0, 0, 0);
      n += int'(!s_csn);
    end
    chk("full_issues", n, 4);
    chk("full_csn", 32'(s_csn), 32'h1);
    chk("full_pc", s_pc, 32'h0);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, 1);
      chk("drain_pc", s_pc, 32'(4 * i));
      chk("drain_v", 32'(s_valid), 32'h1);
      if (i == 1) begin
        chk("resume_csn", 32'(s_csn), 32'h0);
        chk("resume_addr", s_addr, 32'h10);
      end
    end
    do_reset();
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0);
    cycle(1, 32'h100, 0, 1); chk("fl_addr", s_addr, 32'h100); chk("fl_csn", 32'(s_csn), 32'h0);
    cycle(0, 0, 0, 1); chk("fl_v1", 32'(s_valid), 32'h0);
    cycle(0, 0, 0, 1); chk("fl_v2", 32'(s_valid), 32'h1); chk("fl_pc2", s_pc, 32'h100);
    cycle(0, 0, 0, 1); chk("fl_pc3", s_pc, 32'h104);
    cycle(1, 32'hFFFF_FFF8, 0, 1);
    cycle(0, 0, 0, 1); chk("wrap_a1", s_addr, 32'hFFFF_FFFC);
    cycle(0, 0, 0, 1); chk("wrap_a2", s_addr, 32'h0);
    cycle(0, 0, 1, 1); chk("halt_csn", 32'(s_csn), 32'h1);
    cycle(0, 0, 1, 1); chk("halt_csn2", 32'(s_csn), 32'h1);
    cycle(0, 0, 0, 1); chk("halt_resume", s_addr, 32'h4);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
    do_reset();
    cycle(0, 0, 0, 1); chk("rst_restart", s_addr, 32'h0);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      else cycle($urandom_range(0, 15) == 0, $urandom & 32'hFFFF_FFFC,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 2) != 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
